// File: rtl/gamepad_pmod_rx_if.sv
// Gamepad PMOD receiver bus.
// Groups the three serial pins from the PMOD and the decoded controller state
// presented to the demo logic.
//   pmod_data/pmod_clk/pmod_latch : asynchronous serial link pins
//   btn_p1/btn_p2                 : button state per controller, 1 = pressed
//   p1_present/p2_present         : controller connected
//   frame_valid/frame_err         : one-cycle strobes for accepted/rejected frames
//   link_up                       : a good frame arrived recently
// The receiver uses the slave modport; the pin driver / state consumer uses master.
interface gamepad_pmod_rx_if;
    logic        pmod_data;
    logic        pmod_clk;
    logic        pmod_latch;
    logic [11:0] btn_p1;
    logic [11:0] btn_p2;
    logic        p1_present;
    logic        p2_present;
    logic        frame_valid;
    logic        frame_err;
    logic        link_up;

    modport master (
        output pmod_data, pmod_clk, pmod_latch,
        input  btn_p1, btn_p2, p1_present, p2_present, frame_valid, frame_err, link_up
    );

    modport slave (
        input  pmod_data, pmod_clk, pmod_latch,
        output btn_p1, btn_p2, p1_present, p2_present, frame_valid, frame_err, link_up
    );
endinterface

// File: rtl/gamepad_pmod_rx.sv
// Gamepad PMOD serial receiver.
// Synchronises the latch/clock/data pins, shifts one frame per latch, accepts a
// frame only when exactly NBITS bits were shifted, and publishes the button
// state of two controllers. A watchdog drops link_up and clears all controller
// state when no good frame arrives for TIMEOUT_CYCLES clocks.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : gamepad_pmod_rx_if slave (pins in, controller state and strobes out)
module gamepad_pmod_rx #(
    parameter int unsigned NBITS          = 24,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input logic              clk,
    input logic              rst_n,
    gamepad_pmod_rx_if.slave bus
);

    localparam int unsigned FieldW  = 12;
    localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]  CntMax  = 5'd31;
    localparam logic [4:0]  CntFull = 5'(NBITS);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   latch_prev_q, latch_prev_d;
    logic [NBITS-1:0]       shift_q, shift_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic [FieldW-1:0]      btn_p1_q, btn_p1_d;
    logic [FieldW-1:0]      btn_p2_q, btn_p2_d;
    logic                   p1_present_q, p1_present_d;
    logic                   p2_present_q, p2_present_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   link_up_q, link_up_d;

    logic              s_data, s_clk, s_latch;
    logic              clk_rise, latch_rise;
    logic [FieldW-1:0] raw_p1, raw_p2;

    // Data and clock are tapped at the same stage so their relative skew survives.
    assign s_data  = data_sync_q[SYNC_STAGES-1];
    assign s_clk   = clk_sync_q[SYNC_STAGES-1];
    assign s_latch = latch_sync_q[SYNC_STAGES-1];

    assign clk_rise   = s_clk & ~clk_prev_q;
    assign latch_rise = s_latch & ~latch_prev_q;

    // Wire is active-low; player 1 was sent first so it sits in the upper field.
    assign raw_p1 = shift_q[NBITS-1 -: FieldW];
    assign raw_p2 = shift_q[FieldW-1:0];

    always_comb begin
        data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], bus.pmod_data};
        clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], bus.pmod_clk};
        latch_sync_d  = {latch_sync_q[SYNC_STAGES-2:0], bus.pmod_latch};
        clk_prev_d    = s_clk;
        latch_prev_d  = s_latch;

        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        btn_p1_d      = btn_p1_q;
        btn_p2_d      = btn_p2_q;
        p1_present_d  = p1_present_q;
        p2_present_d  = p2_present_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        link_up_d     = link_up_q;
        tmo_d         = (tmo_q == TmoMax) ? tmo_q : tmo_q + TmoW'(1);

        // Latch takes priority; a clock rise in the same cycle is dropped.
        if (latch_rise) begin
            bit_cnt_d = '0;
            if (bit_cnt_q == CntFull) begin
                // All-zeros raw means no controller; all-ones decodes to nothing pressed.
                p1_present_d  = (raw_p1 != '0);
                p2_present_d  = (raw_p2 != '0);
                btn_p1_d      = (raw_p1 != '0) ? ~raw_p1 : '0;
                btn_p2_d      = (raw_p2 != '0) ? ~raw_p2 : '0;
                frame_valid_d = 1'b1;
                link_up_d     = 1'b1;
                tmo_d         = '0;
            end else begin
                frame_err_d = 1'b1;
            end
        end else if (clk_rise) begin
            shift_d = {shift_q[NBITS-2:0], s_data};
            if (bit_cnt_q != CntMax) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end

        // Link lost: forget everything the last good frame told us.
        if (tmo_d == TmoMax) begin
            link_up_d    = 1'b0;
            btn_p1_d     = '0;
            btn_p2_d     = '0;
            p1_present_d = 1'b0;
            p2_present_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync_q   <= '0;
            clk_sync_q    <= '0;
            latch_sync_q  <= '0;
            clk_prev_q    <= 1'b0;
            latch_prev_q  <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            tmo_q         <= '0;
            btn_p1_q      <= '0;
            btn_p2_q      <= '0;
            p1_present_q  <= 1'b0;
            p2_present_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            link_up_q     <= 1'b0;
        end else begin
            data_sync_q   <= data_sync_d;
            clk_sync_q    <= clk_sync_d;
            latch_sync_q  <= latch_sync_d;
            clk_prev_q    <= clk_prev_d;
            latch_prev_q  <= latch_prev_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            tmo_q         <= tmo_d;
            btn_p1_q      <= btn_p1_d;
            btn_p2_q      <= btn_p2_d;
            p1_present_q  <= p1_present_d;
            p2_present_q  <= p2_present_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            link_up_q     <= link_up_d;
        end
    end

    assign bus.btn_p1      = btn_p1_q;
    assign bus.btn_p2      = btn_p2_q;
    assign bus.p1_present  = p1_present_q;
    assign bus.p2_present  = p2_present_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.link_up     = link_up_q;

endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// Testbench for gamepad_pmod_rx: randomized frames checked by a scoreboard.
// Two receivers share the pins: one with a long watchdog for the scoreboard,
// one with a 100-cycle watchdog for the timeout boundary.
module tb_gamepad_pmod_rx;
    localparam int unsigned NBITS  = 24;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned TMO_MN = 20000;
    localparam int unsigned TMO_WD = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gamepad_pmod_rx_if bus ();
    gamepad_pmod_rx_if bus_wd ();

    assign bus_wd.pmod_data  = bus.pmod_data;
    assign bus_wd.pmod_clk   = bus.pmod_clk;
    assign bus_wd.pmod_latch = bus.pmod_latch;

    gamepad_pmod_rx #(.NBITS(NBITS), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO_MN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    gamepad_pmod_rx #(.NBITS(NBITS), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO_WD)) dut_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_wd)
    );

    typedef struct {
        bit          good;
        logic [11:0] p1;
        logic [11:0] p2;
        logic        p1p;
        logic        p2p;
        logic        link;
        int          lcyc;
    } exp_t;

    exp_t expq[$];
    bit   mbits[$];

    // Reference model of the published controller state.
    logic [11:0] m_p1 = '0, m_p2 = '0;
    logic        m_p1p = 1'b0, m_p2p = 1'b0, m_link = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wd_fv_cyc = -1;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every strobe must match the oldest outstanding latch.
    always @(negedge clk) begin
        if (rst_n && (bus.frame_valid === 1'b1 || bus.frame_err === 1'b1)) begin
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected strobe: got valid=%b err=%b, expected none (t=%0t)",
                         bus.frame_valid, bus.frame_err, $time);
            end else begin
                mon_e = expq.pop_front();
                chk("frame_valid", 32'(bus.frame_valid), 32'(mon_e.good));
                chk("frame_err", 32'(bus.frame_err), 32'(!mon_e.good));
                chk("latch latency", cyc - mon_e.lcyc, SYNC + 1);
                chk("btn_p1", 32'(bus.btn_p1), 32'(mon_e.p1));
                chk("btn_p2", 32'(bus.btn_p2), 32'(mon_e.p2));
                chk("p1_present", 32'(bus.p1_present), 32'(mon_e.p1p));
                chk("p2_present", 32'(bus.p2_present), 32'(mon_e.p2p));
                chk("link_up", 32'(bus.link_up), 32'(mon_e.link));
            end
        end
        if (rst_n && bus_wd.frame_valid === 1'b1) wd_fv_cyc = cyc;
    end

    task automatic send_bit(input bit b);
        bus.pmod_data = b;
        repeat ($urandom_range(3, 5)) @(negedge clk);
        bus.pmod_clk = 1'b1;
        mbits.push_back(b);
        repeat ($urandom_range(3, 5)) @(negedge clk);
        bus.pmod_clk = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Raise the latch; with collide the serial clock rises in the same cycle.
    task automatic do_latch(input bit collide);
        exp_t e;
        logic [NBITS-1:0] raw;
        repeat ($urandom_range(3, 5)) @(negedge clk);
        bus.pmod_latch = 1'b1;
        if (collide) bus.pmod_clk = 1'b1;
        e.lcyc = cyc;
        if (mbits.size() == NBITS) begin
            for (int i = 0; i < NBITS; i++) raw[NBITS-1-i] = mbits[i];
            m_p1p  = (raw[23:12] != 12'h000);
            m_p2p  = (raw[11:0] != 12'h000);
            m_p1   = m_p1p ? ~raw[23:12] : 12'h000;
            m_p2   = m_p2p ? ~raw[11:0] : 12'h000;
            m_link = 1'b1;
            e.good = 1'b1;
        end else begin
            e.good = 1'b0;
        end
        e.p1 = m_p1; e.p2 = m_p2; e.p1p = m_p1p; e.p2p = m_p2p; e.link = m_link;
        expq.push_back(e);
        mbits.delete();
        repeat ($urandom_range(3, 5)) @(negedge clk);
        bus.pmod_latch = 1'b0;
        bus.pmod_clk   = 1'b0;
        repeat ($urandom_range(3, 5)) @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && expq.size() != 0; k++) @(negedge clk);
        chk("scoreboard drained", expq.size(), 0);
    endtask

    task automatic check_idle_state(input string tag);
        chk({tag, " btn_p1"}, 32'(bus.btn_p1), 0);
        chk({tag, " btn_p2"}, 32'(bus.btn_p2), 0);
        chk({tag, " presents"}, 32'({bus.p1_present, bus.p2_present}), 0);
        chk({tag, " strobes"}, 32'({bus.frame_valid, bus.frame_err}), 0);
        chk({tag, " link_up"}, 32'(bus.link_up), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.pmod_clk = 1'b0; bus.pmod_latch = 1'b0; bus.pmod_data = 1'b0;
        mbits.delete();
        expq.delete();
        m_p1 = '0; m_p2 = '0; m_p1p = 1'b0; m_p2p = 1'b0; m_link = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_state("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [23:0] rand_frame();
        logic [11:0] f1, f2;
        f1 = 12'($urandom);
        f2 = 12'($urandom);
        case ($urandom_range(0, 3))
            0: f1 = 12'h000;
            1: f1 = 12'hFFF;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: f2 = 12'h000;
            1: f2 = 12'hFFF;
            default: ;
        endcase
        return {f1, f2};
    endfunction

    initial begin
        bus.pmod_data = 1'b0; bus.pmod_clk = 1'b0; bus.pmod_latch = 1'b0;
        do_reset();
        chk("wd reset link_up", 32'(bus_wd.link_up), 0);

        // Good frame, defaults.
        send_word(64'hFFE_FFF, 24); do_latch(1'b0); drain();
        chk("frame1 btn_p1", 32'(bus.btn_p1), 32'h001);
        chk("frame1 btn_p2", 32'(bus.btn_p2), 32'h000);
        chk("frame1 presents", 32'({bus.p1_present, bus.p2_present}), 32'b11);
        chk("frame1 link_up", 32'(bus.link_up), 1);

        // No player 2 controller.
        send_word(64'h7FF_000, 24); do_latch(1'b0); drain();
        chk("frame2 btn_p1", 32'(bus.btn_p1), 32'h800);
        chk("frame2 presents", 32'({bus.p1_present, bus.p2_present}), 32'b10);

        // Short, good, long, saturating burst, good.
        send_word(64'($urandom), 23); do_latch(1'b0);
        send_word(64'(rand_frame()), 24); do_latch(1'b0);
        send_word(64'($urandom), 25); do_latch(1'b0);
        send_word({32'($urandom), 32'($urandom)}, 40); do_latch(1'b0);
        send_word(64'(rand_frame()), 24); do_latch(1'b0);
        drain();

        // Clock and latch rise together: latch only, next frame still counts from 0.
        send_word(64'(rand_frame()), 24); do_latch(1'b1);
        send_word(64'(rand_frame()), 24); do_latch(1'b0);
        drain();

        for (int it = 0; it < 25; it++) begin
            int n;
            n = ($urandom_range(0, 9) < 6) ? 24 : int'($urandom_range(0, 40));
            if (n == 24) send_word(64'(rand_frame()), 24);
            else send_word({32'($urandom), 32'($urandom)}, n);
            do_latch($urandom_range(0, 4) == 0);
        end
        drain();

        // Reset mid-frame discards the partial frame.
        send_word(64'($urandom), 12);
        do_reset();
        send_word(64'(rand_frame()), 24); do_latch(1'b0); drain();
        chk("post-reset link_up", 32'(bus.link_up), 1);

        // Watchdog boundary on the 100-cycle instance.
        wd_fv_cyc = -1;
        send_word(64'h5A5_A5A, 24); do_latch(1'b0);
        for (int k = 0; k < 40 && wd_fv_cyc < 0; k++) @(negedge clk);
        chk("wd frame seen", 32'(wd_fv_cyc >= 0), 1);
        if (wd_fv_cyc >= 0) begin
            while (cyc < wd_fv_cyc + int'(TMO_WD) - 1) @(negedge clk);
            chk("wd link before timeout", 32'(bus_wd.link_up), 1);
            chk("wd btn_p1 before timeout", 32'(bus_wd.btn_p1), 32'hA5A);
            @(negedge clk);
            chk("wd link after timeout", 32'(bus_wd.link_up), 0);
            chk("wd btns after timeout", 32'({bus_wd.btn_p1, bus_wd.btn_p2}), 0);
            chk("wd presents after timeout", 32'({bus_wd.p1_present, bus_wd.p2_present}), 0);
        end
        chk("main link still up", 32'(bus.link_up), 1);
        chk("main btn_p2 held", 32'(bus.btn_p2), 32'h5A5);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got no finish, expected finish by 2ms");
        $fatal(1, "timeout");
    end

endmodule
